// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// ysyx_041461_pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer:
//   FSM state encodings and the watchdog defaults.
package ysyx_041461_pipe_ctrl_pkg;

   typedef enum logic {
      ysyx_041461_PCTRL_RUN       = 1'b0,
      ysyx_041461_PCTRL_TRAP_WAIT = 1'b1
   } pctrl_state_e;

   localparam int unsigned ysyx_041461_PCTRL_WDT_LIMIT = 1024;
   localparam int unsigned ysyx_041461_PCTRL_WDT_W     = 16;

   // A load in EXE whose result the instruction in ID reads; x0 never hazards.
   function automatic logic load_use_hit(
      input logic       exe_valid,
      input logic       exe_is_load,
      input logic [4:0] exe_rd,
      input logic       id_valid,
      input logic       id_use_rs1,
      input logic [4:0] id_rs1,
      input logic       id_use_rs2,
      input logic [4:0] id_rs2
   );
      return exe_valid && exe_is_load && (exe_rd != 5'd0) && id_valid &&
             ((id_use_rs1 && (id_rs1 == exe_rd)) ||
              (id_use_rs2 && (id_rs2 == exe_rd)));
   endfunction

endpackage

// File: rtl/ysyx_041461_pipe_wdt.sv
// ysyx_041461_pipe_wdt
//   PC-freeze watchdog. Counts consecutive cycles with the PC frozen and
//   raises a sticky hang flag once the count reaches WDT_LIMIT.
//   Ports:
//     clk        - clock, rising edge
//     rst        - asynchronous active-low reset
//     pc_enable  - PC load from the sequencer; 1 clears the count
//     wdt_hang   - sticky hang flag, cleared only by reset
module ysyx_041461_pipe_wdt
   import ysyx_041461_pipe_ctrl_pkg::*;
#(
   parameter int unsigned WDT_LIMIT = ysyx_041461_PCTRL_WDT_LIMIT,
   parameter int unsigned WDT_W     = ysyx_041461_PCTRL_WDT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic pc_enable,
   output logic wdt_hang
);

   localparam logic [WDT_W-1:0] LIMIT = WDT_W'(WDT_LIMIT);

   logic [WDT_W-1:0] cnt_q, cnt_d;
   logic             hang_q, hang_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pc_enable) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + WDT_W'(1);
      end
      // Flag rises on the same edge the count lands on the limit.
      hang_d = hang_q | (cnt_d == LIMIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         hang_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hang_q <= hang_d;
      end
   end

   assign wdt_hang = hang_q;

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// ysyx_041461_pipe_ctrl
//   Stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
//   Outputs are combinational from the FSM state and the hazard, busy and
//   redirect inputs; only the state (and the optional watchdog) is registered.
//   Optional watchdog enabled by defining YSYX_041461_PIPE_WDT_EN.
//   Ports:
//     clk, rst                         - clock, async active-low reset
//     id_* / exe_valid/rd/is_load      - load-use hazard detection
//     exe_busy, mem_busy, ifu_busy     - multi-cycle busy inputs
//     exe_redirect, wb_trap            - redirect sources
//     pc_enable, trap_redirect         - PC load and PC mux select
//     *reg_enable, *reg_flush          - pipeline register load / bubble
//     wdt_hang                         - sticky hang flag (0 without watchdog)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RUN       | normal priority-based stall/flush control
//   TRAP_WAIT | trap seen while LSU busy; everything frozen until bus idle
module ysyx_041461_pipe_ctrl
   import ysyx_041461_pipe_ctrl_pkg::*;
#(
   parameter int unsigned WDT_LIMIT = ysyx_041461_PCTRL_WDT_LIMIT,
   parameter int unsigned WDT_W     = ysyx_041461_PCTRL_WDT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic       exe_valid,
   input  logic [4:0] exe_rd,
   input  logic       exe_is_load,
   input  logic       exe_busy,
   input  logic       exe_redirect,
   input  logic       mem_busy,
   input  logic       ifu_busy,
   input  logic       wb_trap,
   output logic       pc_enable,
   output logic       trap_redirect,
   output logic       idreg_enable,
   output logic       exereg_enable,
   output logic       memreg_enable,
   output logic       wbreg_enable,
   output logic       idreg_flush,
   output logic       exereg_flush,
   output logic       memreg_flush,
   output logic       wbreg_flush,
   output logic       wdt_hang
);

   if (WDT_LIMIT >= (2 ** WDT_W)) begin : g_bad_wdt_cfg
      $error("WDT_LIMIT does not fit in WDT_W bits");
   end

   pctrl_state_e state_q, state_d;
   logic         load_use;
   logic         do_trap;

   assign load_use = load_use_hit(exe_valid, exe_is_load, exe_rd, id_valid,
                                  id_use_rs1, id_rs1, id_use_rs2, id_rs2);

   always_comb begin
      state_d       = state_q;
      do_trap       = 1'b0;
      pc_enable     = 1'b0;
      trap_redirect = 1'b0;
      idreg_enable  = 1'b0;
      exereg_enable = 1'b0;
      memreg_enable = 1'b0;
      wbreg_enable  = 1'b0;
      idreg_flush   = 1'b0;
      exereg_flush  = 1'b0;
      memreg_flush  = 1'b0;
      wbreg_flush   = 1'b0;
      // Gating on rst makes a mid-trap-wait reset take effect without a clock.
      if (rst) begin
         case (state_q)
            ysyx_041461_PCTRL_RUN: begin
               if (wb_trap && !mem_busy) begin
                  do_trap = 1'b1;
               end else if (wb_trap) begin
                  state_d = ysyx_041461_PCTRL_TRAP_WAIT;
               end else if (mem_busy) begin
                  wbreg_enable = 1'b1;
                  wbreg_flush  = 1'b1;
               end else if (exe_busy) begin
                  memreg_enable = 1'b1;
                  memreg_flush  = 1'b1;
                  wbreg_enable  = 1'b1;
               end else if (exe_redirect) begin
                  pc_enable     = 1'b1;
                  idreg_enable  = 1'b1;
                  exereg_enable = 1'b1;
                  memreg_enable = 1'b1;
                  wbreg_enable  = 1'b1;
                  idreg_flush   = 1'b1;
                  exereg_flush  = 1'b1;
               end else if (load_use) begin
                  exereg_enable = 1'b1;
                  exereg_flush  = 1'b1;
                  memreg_enable = 1'b1;
                  wbreg_enable  = 1'b1;
               end else if (ifu_busy) begin
                  idreg_enable  = 1'b1;
                  idreg_flush   = 1'b1;
                  exereg_enable = 1'b1;
                  memreg_enable = 1'b1;
                  wbreg_enable  = 1'b1;
               end else begin
                  pc_enable     = 1'b1;
                  idreg_enable  = 1'b1;
                  exereg_enable = 1'b1;
                  memreg_enable = 1'b1;
                  wbreg_enable  = 1'b1;
               end
            end
            ysyx_041461_PCTRL_TRAP_WAIT: begin
               // wb_trap is deliberately ignored here; the trap was latched.
               if (!mem_busy) begin
                  do_trap = 1'b1;
                  state_d = ysyx_041461_PCTRL_RUN;
               end
            end
            default: state_d = ysyx_041461_PCTRL_RUN;
         endcase

         if (do_trap) begin
            trap_redirect = 1'b1;
            pc_enable     = 1'b1;
            idreg_enable  = 1'b1;
            exereg_enable = 1'b1;
            memreg_enable = 1'b1;
            wbreg_enable  = 1'b1;
            idreg_flush   = 1'b1;
            exereg_flush  = 1'b1;
            memreg_flush  = 1'b1;
            wbreg_flush   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ysyx_041461_PCTRL_RUN;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef YSYX_041461_PIPE_WDT_EN
   ysyx_041461_pipe_wdt #(
      .WDT_LIMIT (WDT_LIMIT),
      .WDT_W     (WDT_W)
   ) u_wdt (
      .clk       (clk),
      .rst       (rst),
      .pc_enable (pc_enable),
      .wdt_hang  (wdt_hang)
   );
`else
   assign wdt_hang = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Scoreboard bench for ysyx_041461_pipe_ctrl. Stimulus is applied shortly
// after each rising edge; the reference model's expected outputs are queued
// and a monitor compares them on the falling edge.
module tb_ysyx_041461_pipe_ctrl;

   localparam int unsigned LIMIT = 8;
`ifdef YSYX_041461_PIPE_WDT_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   typedef struct {
      bit       rst_n;
      bit       id_valid;
      bit [4:0] id_rs1;
      bit [4:0] id_rs2;
      bit       use1;
      bit       use2;
      bit       exe_valid;
      bit [4:0] exe_rd;
      bit       is_load;
      bit       exe_busy;
      bit       redirect;
      bit       mem_busy;
      bit       ifu_busy;
      bit       wb_trap;
   } stim_t;

   typedef struct {
      logic [10:0] exp;
      string       tag;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs1, id_use_rs2, exe_valid, exe_is_load;
   logic [4:0] id_rs1, id_rs2, exe_rd;
   logic       exe_busy, exe_redirect, mem_busy, ifu_busy, wb_trap;
   logic       pc_enable, trap_redirect;
   logic       idreg_enable, exereg_enable, memreg_enable, wbreg_enable;
   logic       idreg_flush, exereg_flush, memreg_flush, wbreg_flush;
   logic       wdt_hang;

   int vectors = 0;
   int miscompares = 0;
   sb_t sbq[$];

   // Reference model state: a trap deferred behind a bus wait, and the watchdog.
   bit pend_m = 1'b0;
   int wdt_cnt_m = 0;
   bit hang_m = 1'b0;

   always #5 clk = ~clk;

   ysyx_041461_pipe_ctrl #(.WDT_LIMIT(LIMIT), .WDT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_is_load(exe_is_load),
      .exe_busy(exe_busy), .exe_redirect(exe_redirect), .mem_busy(mem_busy),
      .ifu_busy(ifu_busy), .wb_trap(wb_trap),
      .pc_enable(pc_enable), .trap_redirect(trap_redirect),
      .idreg_enable(idreg_enable), .exereg_enable(exereg_enable),
      .memreg_enable(memreg_enable), .wbreg_enable(wbreg_enable),
      .idreg_flush(idreg_flush), .exereg_flush(exereg_flush),
      .memreg_flush(memreg_flush), .wbreg_flush(wbreg_flush),
      .wdt_hang(wdt_hang)
   );

   // Model in pipeline terms: a stall freezes units 0..n-1 (PC, ID, EXE, MEM)
   // and inserts a bubble into unit n; redirect and trap squash younger work.
   // Result packing: {hang, pc_en, trap, en_id, en_exe, en_mem, en_wb,
   //                  fl_id, fl_exe, fl_mem, fl_wb}
   function automatic logic [9:0] ref_out(input stim_t s, input bit pend,
                                          output bit pend_nx);
      bit [4:0] en;
      bit [4:0] fl;
      bit       trap;
      int       freeze;
      bit       hazard;
      pend_nx = 1'b0;
      en = 5'b11111;
      fl = 5'b00000;
      trap = 1'b0;
      freeze = 0;
      if (!s.rst_n) return 10'd0;
      hazard = s.exe_valid && s.is_load && s.exe_rd != 0 && s.id_valid &&
               ((s.use1 && s.id_rs1 == s.exe_rd) || (s.use2 && s.id_rs2 == s.exe_rd));
      if (pend || s.wb_trap) begin
         if (s.mem_busy) begin
            en = 5'b00000;
            pend_nx = 1'b1;
         end else begin
            trap = 1'b1;
            fl = 5'b11110;
         end
      end else begin
         if (s.mem_busy) freeze = 4;
         else if (s.exe_busy) freeze = 3;
         else if (s.redirect) fl = 5'b00110;
         else if (hazard) freeze = 2;
         else if (s.ifu_busy) freeze = 1;
         for (int i = 0; i < freeze; i++) en[i] = 1'b0;
         if (freeze > 0) fl[freeze] = 1'b1;
      end
      return {en[0], trap, en[1], en[2], en[3], en[4], fl[1], fl[2], fl[3], fl[4]};
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{rst_n: 1'b1, default: '0};
      return s;
   endfunction

   task automatic apply(input stim_t s, input string tag);
      logic [9:0] e;
      bit         pn;
      sb_t        item;
      @(posedge clk);
      #1;
      rst = s.rst_n;
      id_valid = s.id_valid; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
      id_use_rs1 = s.use1; id_use_rs2 = s.use2;
      exe_valid = s.exe_valid; exe_rd = s.exe_rd; exe_is_load = s.is_load;
      exe_busy = s.exe_busy; exe_redirect = s.redirect; mem_busy = s.mem_busy;
      ifu_busy = s.ifu_busy; wb_trap = s.wb_trap;
      e = ref_out(s, pend_m, pn);
      if (!s.rst_n) begin
         pend_m = 1'b0;
         wdt_cnt_m = 0;
         hang_m = 1'b0;
      end
      item.exp = {hang_m, e};
      item.tag = tag;
      sbq.push_back(item);
      // Advance the model across the coming rising edge.
      if (s.rst_n) begin
         pend_m = pn;
         if (WDT_ON) begin
            if (e[9]) wdt_cnt_m = 0;
            else if (wdt_cnt_m < int'(LIMIT)) wdt_cnt_m++;
            if (wdt_cnt_m == int'(LIMIT)) hang_m = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      logic [10:0] got;
      sb_t         item;
      got = {wdt_hang, pc_enable, trap_redirect, idreg_enable, exereg_enable,
             memreg_enable, wbreg_enable, idreg_flush, exereg_flush,
             memreg_flush, wbreg_flush};
      if (sbq.size() > 0) begin
         item = sbq.pop_front();
         vectors++;
         if (got !== item.exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (hang,pc,trap,en[id..wb],fl[id..wb])",
                     item.tag, got, item.exp);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      rst = 1'b0;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      exe_valid = 0; exe_rd = 0; exe_is_load = 0; exe_busy = 0;
      exe_redirect = 0; mem_busy = 0; ifu_busy = 0; wb_trap = 0;

      s = idle(); s.rst_n = 1'b0; s.wb_trap = 1'b1; s.mem_busy = 1'b1;
      repeat (2) apply(s, "reset");
      apply(idle(), "normal_flow");

      // Load-use on rs2, then same with x0.
      s = idle();
      s.exe_valid = 1; s.is_load = 1; s.exe_rd = 5; s.id_valid = 1;
      s.use2 = 1; s.id_rs2 = 5;
      apply(s, "load_use");
      s.exe_rd = 0; s.id_rs2 = 0;
      apply(s, "load_use_x0");

      // Redirect beats load-use and ifu_busy.
      s.exe_rd = 5; s.id_rs2 = 5; s.redirect = 1; s.ifu_busy = 1;
      apply(s, "redirect_prio");

      // Multi-cycle EXE for three cycles, then normal.
      s = idle(); s.exe_busy = 1;
      repeat (3) apply(s, "exe_busy");
      apply(idle(), "exe_busy_done");

      // Trap during bus wait, then release.
      s = idle(); s.wb_trap = 1; s.mem_busy = 1;
      repeat (4) apply(s, "trap_wait");
      s.mem_busy = 0;
      apply(s, "trap_release");
      apply(idle(), "after_trap");

      // Trap wait ignores a dropped wb_trap, then reset aborts it.
      s = idle(); s.wb_trap = 1; s.mem_busy = 1;
      apply(s, "trap_enter");
      s.wb_trap = 0;
      apply(s, "trap_hold");
      s.rst_n = 1'b0;
      apply(s, "reset_mid_trap");
      apply(idle(), "run_after_reset");

      // PC frozen long enough to trip the watchdog, then released.
      s = idle(); s.ifu_busy = 1;
      repeat (10) apply(s, "ifu_freeze");
      repeat (2) apply(idle(), "post_freeze");

      for (int n = 0; n < 400; n++) begin
         s.rst_n     = ($urandom_range(0, 63) != 0);
         s.id_valid  = $urandom_range(0, 3) != 0;
         s.id_rs1    = 5'($urandom_range(0, 3));
         s.id_rs2    = 5'($urandom_range(0, 3));
         s.use1      = $urandom_range(0, 1) != 0;
         s.use2      = $urandom_range(0, 1) != 0;
         s.exe_valid = $urandom_range(0, 3) != 0;
         s.exe_rd    = 5'($urandom_range(0, 3));
         s.is_load   = $urandom_range(0, 1) != 0;
         s.exe_busy  = $urandom_range(0, 4) == 0;
         s.redirect  = $urandom_range(0, 5) == 0;
         s.mem_busy  = $urandom_range(0, 3) == 0;
         s.ifu_busy  = $urandom_range(0, 3) == 0;
         s.wb_trap   = $urandom_range(0, 7) == 0;
         apply(s, "random");
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ysyx_041461_pipe_ctrl.md
Name: ysyx_041461_pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV64 pipeline (IF → IDreg → EXEreg → MEMreg → WBreg).
- Each cycle, drives the enable and bubble-insert (flush) control of every pipeline register and the PC, from:
  - hazard inputs: load-use;
  - multi-cycle busy inputs: EXE unit, LSU bus wait, IFU fetch wait;
  - redirect inputs: EXE branch/jump, WB trap/mret.
- A small FSM defers trap redirection while an LSU bus transaction is outstanding.

Parameters:
- WDT_LIMIT, 1024, consecutive PC-frozen cycles before the hang flag is raised (used only with the optional feature).
- WDT_W, 16, watchdog counter width; WDT_LIMIT must be < 2^WDT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- exe_valid  in  1  EXE stage holds a valid instruction.
- exe_rd  in  5  EXE destination register.
- exe_is_load  in  1  EXE instruction is a load.
- exe_busy  in  1  multi-cycle EXE unit (mul/div) not finished.
- exe_redirect  in  1  EXE branch/jump taken; PC mux selects the EXE target.
- mem_busy  in  1  LSU bus transaction outstanding.
- ifu_busy  in  1  instruction fetch not yet returned.
- wb_trap  in  1  valid WB instruction is ecall/mret/exception; held while WB is frozen.
- pc_enable  out  1  PC register load.
- trap_redirect  out  1  PC mux selects the CSR trap/mret target this cycle.
- idreg_enable, exereg_enable, memreg_enable, wbreg_enable  out  1 each  pipeline register load enables.
- idreg_flush, exereg_flush, memreg_flush, wbreg_flush  out  1 each  when set with the matching enable, the register loads a NOP bubble (valid=0, all ctrl fields NOP).
- wdt_hang  out  1  sticky hang flag (optional feature).

Behaviour:
- Reset, while rst=0:
  - state=RUN.
  - All enables=0, all flushes=0, trap_redirect=0, wdt_hang=0.
  - Outputs are gated combinationally by rst, so reset asserted mid-trap-wait aborts immediately.
- Outputs are combinational from state and inputs, with zero latency. Only state (and the watchdog) is registered.
- FSM states: RUN, TRAP_WAIT.
- RUN, in strict priority order:
  1. wb_trap && !mem_busy:
     - trap_redirect=1, pc_enable=1.
     - All four register enables=1 and all four flushes=1.
     - Stay in RUN.
  2. wb_trap && mem_busy:
     - All enables=0.
     - Next state TRAP_WAIT.
  3. mem_busy:
     - pc, idreg, exereg, memreg enables=0.
     - wbreg_enable=1 with wbreg_flush=1.
  4. exe_busy:
     - pc, idreg, exereg enables=0.
     - memreg_enable=1 with memreg_flush=1.
     - wbreg_enable=1.
  5. exe_redirect:
     - All enables=1.
     - idreg_flush=1, exereg_flush=1.
     - This wins over load-use and ifu_busy.
  6. Load-use:
     - Condition: exe_valid && exe_is_load && exe_rd≠0 && id_valid && ((id_use_rs1 && id_rs1==exe_rd) || (id_use_rs2 && id_rs2==exe_rd)).
     - pc and idreg enables=0.
     - exereg_enable=1 with exereg_flush=1.
     - memreg and wbreg enables=1.
  7. ifu_busy:
     - pc_enable=0.
     - idreg_enable=1 with idreg_flush=1.
     - Other enables=1.
  8. Otherwise: all enables=1, no flush.
- TRAP_WAIT:
  - While mem_busy=1: all enables=0.
  - When mem_busy=0: perform the trap-redirect outputs of rule 1 and go to RUN.
  - wb_trap is not re-sampled in this state.
- Any flush=1 is only asserted together with its enable=1.
- Register index 0 is never a load-use hazard.

Optional Feature:
- Macro: YSYX_041461_PIPE_WDT_EN.
- Defined:
  - A WDT_W-bit counter increments on every cycle with pc_enable=0 and clears on every cycle with pc_enable=1.
  - When the counter reaches WDT_LIMIT, wdt_hang is set and stays set until reset; the counter saturates.
- Undefined: no counter; wdt_hang tied to 0.

Decomposition:
- Shared macro file gains the state encodings ysyx_041461_PCTRL_RUN=1'b0 and ysyx_041461_PCTRL_TRAP_WAIT=1'b1.
- Shared macro file gains the WDT_LIMIT default.
- One natural sub-module: ysyx_041461_pipe_wdt, containing the counter and the sticky flag, instantiated only under the macro.

Test Plan:
- Load-use stall:
  - Stimulus: exe_valid=1, exe_is_load=1, exe_rd=5; id_valid=1, id_use_rs2=1, id_rs2=5.
  - Response: pc/idreg enables=0; exereg_enable=1 with exereg_flush=1.
  - Repeat with exe_rd=0 → no stall.
- Redirect priority:
  - Stimulus: exe_redirect=1 together with the load-use hazard and ifu_busy=1.
  - Response: all enables=1, idreg_flush=1, exereg_flush=1, no other flush.
- Multi-cycle EXE:
  - Stimulus: exe_busy held for 3 cycles.
  - Response: pc/idreg/exereg enables=0 and memreg bubble each cycle; normal flow on cycle 4.
- Trap during bus wait:
  - Stimulus: wb_trap=1 with mem_busy=1 for 4 cycles.
  - Response: all enables=0 for 4 cycles (state TRAP_WAIT).
  - Then on the cycle mem_busy=0: trap_redirect=1 and all four flushes=1; next cycle state=RUN.
- Reset mid-operation: assert rst=0 asynchronously while in TRAP_WAIT → all outputs 0 immediately; after release, state=RUN.
- Watchdog (macro on, WDT_LIMIT=8):
  - ifu_busy held for 8 cycles → wdt_hang=1 on the 8th edge.
  - wdt_hang stays 1 after ifu_busy drops and clears only on reset.
